result_collector: RTL
=====================

// Module: result_collector
// PURPOSE
//   Downstream stage of the arithmetic controller. Captures each 32-bit result it publishes
//   over the four-phase stable/ack handshake (input_z / input_z_stable / output_z_ack).
//   Buffers results in a small FIFO with a sequence tag, then drains them to a consumer over
//   valid/ready. Back-pressures the controller by withholding ack while the FIFO is full.
// PARAMETERS
//   DATA_W  32  result width
//   DEPTH   4   FIFO entries; power of two, >= 2
//   SEQ_W   8   sequence tag width; tag wraps modulo 2^SEQ_W
//   CNT_W   16  stall counter width; counter saturates
// PORTS
//   clk             in   1              single clock; all logic on posedge
//   rst_n           in   1              synchronous, active-low reset
//   input_z         in   DATA_W         result from controller; valid while input_z_stable=1
//   input_z_stable  in   1              producer strobe (four-phase request)
//   output_z_ack    out  1              four-phase acknowledge to producer
//   out_data        out  DATA_W         head-of-FIFO result
//   out_seq         out  SEQ_W          tag of head entry
//   out_valid       out  1              FIFO non-empty
//   out_ready       in   1              consumer accepts head when out_valid && out_ready
//   fill_level      out  log2(DEPTH)+1  current entry count, 0..DEPTH
//   stall_count     out  CNT_W          cycles spent in IDLE with stable=1 and FIFO full
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, output_z_ack=0, FIFO emptied (out_valid=0,
//     fill_level=0), out_data=0, out_seq=0, next tag=0, stall_count=0. Reset mid-handshake:
//     ack is 0 in the cycle after reset. Buffered entries are discarded.
//   Capture FSM, 2 states, all outputs registered:
//     IDLE: ack=0. If input_z_stable=1 and FIFO not full: write {input_z, tag} at this edge,
//       tag<=tag+1, go to ACK. If stable=1 and full: stay, stall_count+=1 (saturates at all-ones).
//     ACK: ack=1. Stay while input_z_stable=1. On stable=0, go to IDLE; ack is 0 the next cycle.
//   A result is captured exactly once per handshake. The earliest next capture is the cycle after
//     returning to IDLE. Latency from stable rising (FIFO not full) to ack high: 1 cycle.
//   Full is evaluated before any same-cycle pop. With full and a pop in the same cycle, no capture
//     happens that cycle; the capture occurs on the next edge.
//   Read side: out_data/out_seq show the head entry combinationally from FIFO storage whenever
//     out_valid=1. They are don't-care when out_valid=0. A pop occurs on out_valid && out_ready.
//     out_ready with an empty FIFO has no effect.
//   Simultaneous push and pop with the FIFO neither empty nor full: both happen and fill_level is unchanged.
//   Push into an empty FIFO: out_valid=1 on the next cycle (no bypass).
//   Pointers wrap modulo DEPTH. The tag wraps from 2^SEQ_W-1 to 0 without a gap.
//   input_z is sampled only at the capture edge. Changes during ACK are ignored.
// TESTING
//   T1 single result: z=0x0000_00A5, stable pulse, consumer ready -> ack high 1 cycle after
//      stable; out_valid with out_data=0xA5, out_seq=0; fill returns to 0 after pop.
//   T2 fill + backpressure: DEPTH=4, out_ready=0, five handshakes z=1..5 -> first four acked;
//      fifth sees ack=0, stall_count increments every cycle; after one pop, z=5 acked (seq 4).
//   T3 ordering: stream z=0x10,0x20,0x30 with random out_ready -> outputs in order with
//      seq 0,1,2, no duplicates, no drops.
//   T4 tag wrap: SEQ_W=2, six results -> out_seq 0,1,2,3,0,1.
//   T5 reset mid-handshake: rst_n=0 while in ACK with 2 entries buffered -> next cycle ack=0,
//      out_valid=0, fill_level=0, stall_count=0; first new result tagged 0.
//   T6 simultaneous push/pop at fill_level=2 -> fill_level stays 2; popped/pushed data correct.

Source files
------------

// File: rtl/result_collector_if.sv
// ============================================================================
// Module      : result_collector_if
// Description : Capture handshake, drain stream and status bundle of the
//               result collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_collector_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SEQ_W  = 8,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned c_FW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] input_z;
  logic              input_z_stable;
  logic              output_z_ack;
  logic [DATA_W-1:0] out_data;
  logic [SEQ_W-1:0]  out_seq;
  logic              out_valid;
  logic              out_ready;
  logic [c_FW-1:0]   fill_level;
  logic [CNT_W-1:0]  stall_count;

  // Environment side: producer of results and consumer of the drained stream.
  modport master (
    output input_z, input_z_stable, out_ready,
    input  output_z_ack, out_data, out_seq, out_valid, fill_level, stall_count
  );

  modport slave (
    input  input_z, input_z_stable, out_ready,
    output output_z_ack, out_data, out_seq, out_valid, fill_level, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/result_collector.sv
// ============================================================================
// Module      : result_collector
// Description : Captures controller results over a four-phase stable/ack
//               handshake, tags and buffers them, drains them over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_collector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SEQ_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  result_collector_if.slave bus
);
  localparam int unsigned c_AW = $clog2(DEPTH);
  localparam int unsigned c_FW = c_AW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_FW-1:0]   r_count;
  logic [SEQ_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_stall;
  logic              r_ack;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_stall;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign w_full  = (r_count == c_FW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.input_z_stable) begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            w_stall = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (!bus.input_z_stable) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == S_ACK);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tag    <= '0;
      r_stall  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
        r_tag    <= r_tag + SEQ_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_FW'(1);
        2'b01:   r_count <= r_count - c_FW'(1);
        default: r_count <= r_count;
      endcase
      if (w_stall && (r_stall != '1)) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem_data[r_wr_ptr] <= bus.input_z;
      r_mem_seq[r_wr_ptr]  <= r_tag;
    end
  end

  assign bus.output_z_ack = r_ack;
  assign bus.out_valid    = !w_empty;
  assign bus.out_data     = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.out_seq      = w_empty ? '0 : r_mem_seq[r_rd_ptr];
  assign bus.fill_level   = r_count;
  assign bus.stall_count  = r_stall;

endmodule

`default_nettype wire
